vend_ctrl_multi: RTL and testbench

- Parametrised multi-item vending controller.
- Accepts coins of five fixed denominations (5, 10, 20, 50, 100) into a running credit.
- Serves repeated priced selections with quantity against per-item stock, and returns change one coin per handshake.
- Sits between the coin acceptor, the keypad/selection front end, the dispenser and the change hopper.

---
 rtl/vend_ctrl_multi.sv | 238 +++++++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_multi
// Purpose  : Multi-item vending controller: coin credit, priced selections
//            with quantity against per-item stock, greedy change payout.
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl_multi #(
    parameter int                               NUM_ITEMS  = 5,
    parameter int                               PRICE_W    = 8,
    parameter logic [NUM_ITEMS*PRICE_W-1:0]     PRICES     = {8'd135, 8'd75, 8'd5, 8'd45, 8'd10},
    parameter int                               QTY_W      = 3,
    parameter int                               STOCK_W    = 4,
    parameter int                               INIT_STOCK = 10,
    parameter int                               CREDIT_W   = 10,
    parameter int                               MAX_CREDIT = 500
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin_valid,
    input  logic [2:0]                      coin_sel,
    output logic                            coin_reject,
    input  logic                            sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]    sel_item,
    input  logic [QTY_W-1:0]                sel_qty,
    input  logic                            cancel,
    input  logic                            restock_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]    restock_item,
    input  logic [STOCK_W-1:0]              restock_qty,
    output logic                            vend_valid,
    output logic [$clog2(NUM_ITEMS)-1:0]    vend_item,
    output logic [QTY_W-1:0]                vend_qty,
    output logic                            err_valid,
    output logic [1:0]                      err_code,
    output logic                            chg_valid,
    output logic [2:0]                      chg_denom,
    input  logic                            chg_ready,
    output logic [CREDIT_W-1:0]             credit,
    output logic [NUM_ITEMS*STOCK_W-1:0]    stock_flat,
    output logic                            busy
);

    localparam int c_item_w = $clog2(NUM_ITEMS);
    localparam int c_cost_w = PRICE_W + QTY_W;
    localparam int c_cmp_w  = (c_cost_w > CREDIT_W) ? c_cost_w : CREDIT_W;
    localparam int c_sum_w  = ((STOCK_W > QTY_W) ? STOCK_W : QTY_W) + 2;
    localparam logic [STOCK_W-1:0]  c_stock_max  = '1;
    localparam logic [CREDIT_W:0]   c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_CHECK  = 3'd2,
        S_VEND   = 3'd3,
        S_CHANGE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CREDIT_W-1:0]    r_credit;
    logic [CREDIT_W-1:0]    w_credit_nxt;
    logic [STOCK_W-1:0]     r_stock     [NUM_ITEMS];
    logic [STOCK_W-1:0]     w_stock_nxt [NUM_ITEMS];
    logic [STOCK_W-1:0]     w_cur_stock;
    logic [c_item_w-1:0]    r_item;
    logic [QTY_W-1:0]       r_qty;
    logic [c_cost_w-1:0]    r_cost;

    logic                   r_coin_reject;
    logic                   r_vend_valid;
    logic [c_item_w-1:0]    r_vend_item;
    logic [QTY_W-1:0]       r_vend_qty;
    logic                   r_err_valid;
    logic [1:0]             r_err_code;

    logic                   w_idle_hold;
    logic [CREDIT_W:0]      w_coin_sum;
    logic                   w_coin_ok;
    logic                   w_capture;
    logic                   w_bad;
    logic                   w_short;
    logic                   w_poor;
    logic                   w_ok;
    logic                   w_vend_go;
    logic                   w_err_go;
    logic [1:0]             w_err_code;
    logic [2:0]             w_chg_code;
    logic                   w_chg_valid;
    logic                   w_chg_take;

    function automatic logic [CREDIT_W-1:0] f_denom_val(input logic [2:0] code);
        case (code)
            3'd0:    f_denom_val = CREDIT_W'(5);
            3'd1:    f_denom_val = CREDIT_W'(10);
            3'd2:    f_denom_val = CREDIT_W'(20);
            3'd3:    f_denom_val = CREDIT_W'(50);
            3'd4:    f_denom_val = CREDIT_W'(100);
            default: f_denom_val = '0;
        endcase
    endfunction

    // Credit is always a multiple of 5, so the greedy pick always terminates.
    function automatic logic [2:0] f_greedy(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(100))     f_greedy = 3'd4;
        else if (c >= CREDIT_W'(50)) f_greedy = 3'd3;
        else if (c >= CREDIT_W'(20)) f_greedy = 3'd2;
        else if (c >= CREDIT_W'(10)) f_greedy = 3'd1;
        else                         f_greedy = 3'd0;
    endfunction

    function automatic logic [PRICE_W-1:0] f_price(input logic [c_item_w-1:0] item);
        f_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(item) == i) f_price = PRICES[i*PRICE_W +: PRICE_W];
        end
    endfunction

    always_comb begin
        w_cur_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(r_item) == i) w_cur_stock = r_stock[i];
        end
    end

    always_comb begin
        w_idle_hold = (r_state == S_IDLE) || (r_state == S_HOLD);
        w_coin_sum  = {1'b0, r_credit} + {1'b0, f_denom_val(coin_sel)};
        w_coin_ok   = coin_valid && w_idle_hold && (coin_sel <= 3'd4) && (w_coin_sum <= c_max_credit);
        w_capture   = w_idle_hold && sel_valid && !cancel;

        w_bad       = (int'(r_item) >= NUM_ITEMS) || (r_qty == '0);
        w_short     = c_sum_w'(w_cur_stock) < c_sum_w'(r_qty);
        w_poor      = c_cmp_w'(r_cost) > c_cmp_w'(r_credit);
        w_ok        = !w_bad && !w_short && !w_poor;
        w_vend_go   = (r_state == S_CHECK) && w_ok;
        w_err_go    = (r_state == S_CHECK) && !w_ok;
        w_err_code  = w_bad ? 2'd3 : (w_short ? 2'd2 : 2'd1);

        w_chg_code  = f_greedy(r_credit);
        w_chg_valid = (r_state == S_CHANGE) && (r_credit != '0);
        w_chg_take  = w_chg_valid && chg_ready;
    end

    // Next-state and credit update.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_coin_ok) w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                if (cancel) begin
                    if (r_state == S_HOLD) w_state_nxt = S_CHANGE;
                    else if (w_coin_ok)    w_state_nxt = S_HOLD;
                end else if (sel_valid) begin
                    w_state_nxt = S_CHECK;
                end else if (w_coin_ok) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_VEND;
                if (w_ok) w_credit_nxt = CREDIT_W'(c_cmp_w'(r_credit) - c_cmp_w'(r_cost));
            end
            S_VEND: begin
                w_state_nxt = (r_credit != '0) ? S_HOLD : S_IDLE;
            end
            S_CHANGE: begin
                if (w_chg_take) w_credit_nxt = r_credit - f_denom_val(w_chg_code);
                if (w_credit_nxt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
            logic [c_sum_w-1:0] w_inc;
            logic [c_sum_w-1:0] w_dec;
            logic [c_sum_w-1:0] w_sum;
            assign w_inc = (restock_valid && int'(restock_item) == gi) ? c_sum_w'(restock_qty) : '0;
            assign w_dec = (w_vend_go && int'(r_item) == gi) ? c_sum_w'(r_qty) : '0;
            // A successful vend guarantees stock >= qty, so the sum never underflows.
            assign w_sum = c_sum_w'(r_stock[gi]) + w_inc - w_dec;
            assign w_stock_nxt[gi] = (w_sum > c_sum_w'(c_stock_max)) ? c_stock_max : w_sum[STOCK_W-1:0];
            assign stock_flat[gi*STOCK_W +: STOCK_W] = r_stock[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit      <= '0;
            r_item        <= '0;
            r_qty         <= '0;
            r_cost        <= '0;
            r_coin_reject <= 1'b0;
            r_vend_valid  <= 1'b0;
            r_vend_item   <= '0;
            r_vend_qty    <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_credit      <= w_credit_nxt;
            r_coin_reject <= coin_valid && !w_coin_ok;
            r_vend_valid  <= w_vend_go;
            r_err_valid   <= w_err_go;
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= w_stock_nxt[i];
            if (w_capture) begin
                r_item <= sel_item;
                r_qty  <= sel_qty;
                r_cost <= c_cost_w'(f_price(sel_item)) * c_cost_w'(sel_qty);
            end
            if (w_vend_go) begin
                r_vend_item <= r_item;
                r_vend_qty  <= r_qty;
            end
            if (w_err_go) r_err_code <= w_err_code;
        end
    end

    assign coin_reject = r_coin_reject;
    assign vend_valid  = r_vend_valid;
    assign vend_item   = r_vend_item;
    assign vend_qty    = r_vend_qty;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign chg_valid   = w_chg_valid;
    assign chg_denom   = w_chg_valid ? w_chg_code : 3'd0;
    assign credit      = r_credit;
    assign busy        = (r_state == S_CHECK) || (r_state == S_VEND) || (r_state == S_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl_multi
// Purpose  : Self-checking bench for vend_ctrl_multi (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid, coin_reject;
    logic [2:0]  coin_sel;
    logic        sel_valid;
    logic [2:0]  sel_item;
    logic [2:0]  sel_qty;
    logic        cancel;
    logic        restock_valid;
    logic [2:0]  restock_item;
    logic [3:0]  restock_qty;
    logic        vend_valid;
    logic [2:0]  vend_item;
    logic [2:0]  vend_qty;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        chg_valid;
    logic [2:0]  chg_denom;
    logic        chg_ready;
    logic [9:0]  credit;
    logic [19:0] stock_flat;
    logic        busy;

    vend_ctrl_multi dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_item(sel_item), .sel_qty(sel_qty),
        .cancel(cancel),
        .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty),
        .vend_valid(vend_valid), .vend_item(vend_item), .vend_qty(vend_qty),
        .err_valid(err_valid), .err_code(err_code),
        .chg_valid(chg_valid), .chg_denom(chg_denom), .chg_ready(chg_ready),
        .credit(credit), .stock_flat(stock_flat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_vend;
        logic [2:0] item;
        logic [2:0] qty;
        logic [1:0] code;
        int         cyc;
        logic [9:0] credit;
    } exp_t;

    typedef struct {
        logic [3:0] c0;
        logic [3:0] c1;
        logic [2:0] item;
        logic [2:0] qty;
        bit         is_vend;
        logic [1:0] code;
        logic [9:0] credit;
        logic [3:0] stock;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [9:0] dval(input logic [2:0] code);
        case (code)
            3'd0:    dval = 10'd5;
            3'd1:    dval = 10'd10;
            3'd2:    dval = 10'd20;
            3'd3:    dval = 10'd50;
            default: dval = 10'd100;
        endcase
    endfunction

    // Scoreboard consumer: every outcome pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && (vend_valid || err_valid)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_outcome: got vend=%0d err=%0d, expected none", vend_valid, err_valid);
            end else begin
                mon_e = sb_q.pop_front();
                chk("outcome_kind", vend_valid, mon_e.is_vend);
                chk("outcome_excl", vend_valid & err_valid, 0);
                if (mon_e.is_vend) begin
                    chk("vend_item", vend_item, mon_e.item);
                    chk("vend_qty", vend_qty, mon_e.qty);
                end else begin
                    chk("err_code", err_code, mon_e.code);
                end
                chk("outcome_latency", cyc, mon_e.cyc);
                chk("outcome_credit", credit, mon_e.credit);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [2:0] code, input bit rej);
        coin_valid = 1'b1;
        coin_sel   = code;
        tick();
        coin_valid = 1'b0;
        chk("coin_reject", coin_reject, rej);
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic restock(input logic [2:0] item, input logic [3:0] q);
        restock_valid = 1'b1;
        restock_item  = item;
        restock_qty   = q;
        tick();
        restock_valid = 1'b0;
    endtask

    // rs_qty != 0 restocks the same item during the CHECK cycle.
    task automatic do_sel(input logic [2:0] item, input logic [2:0] qty, input bit is_vend,
                          input logic [1:0] code, input logic [9:0] ecr, input logic [3:0] rs_qty);
        exp_t e;
        e.is_vend = is_vend;
        e.item    = item;
        e.qty     = qty;
        e.code    = code;
        e.cyc     = cyc + 2;
        e.credit  = ecr;
        sb_q.push_back(e);
        sel_valid = 1'b1;
        sel_item  = item;
        sel_qty   = qty;
        tick();
        sel_valid = 1'b0;
        chk("busy_in_check", busy, 1);
        if (rs_qty != 4'd0) begin
            restock_valid = 1'b1;
            restock_item  = item;
            restock_qty   = rs_qty;
        end
        tick();
        restock_valid = 1'b0;
        for (int k = 0; k < 6 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL outcome_timeout: got %0d outcomes missing, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_change(input logic [9:0] start, input logic [14:0] codes, input int n);
        logic [9:0] cur;
        logic [2:0] d;
        cur = start;
        for (int k = 0; k < n; k++) begin
            d = codes[3*k +: 3];
            chk("chg_valid", chg_valid, 1);
            chk("chg_denom", chg_denom, d);
            chk("chg_credit", credit, cur);
            chg_ready = 1'b1;
            tick();
            cur = cur - dval(d);
        end
        chg_ready = 1'b0;
        chk("chg_done_valid", chg_valid, 0);
        chk("chg_done_busy", busy, 0);
        chk("chg_done_credit", credit, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Prices: item0=10 item1=45 item2=5 item3=75 item4=135; stock starts at 10.
        vecs[0]  = '{4'd4, 4'd3, 3'd4, 3'd1, 1'b1, 2'd0, 10'd15,  4'd9};
        vecs[1]  = '{4'hF, 4'hF, 3'd0, 3'd2, 1'b0, 2'd1, 10'd15,  4'd10};
        vecs[2]  = '{4'd0, 4'hF, 3'd0, 3'd2, 1'b1, 2'd0, 10'd0,   4'd8};
        vecs[3]  = '{4'hF, 4'hF, 3'd5, 3'd1, 1'b0, 2'd3, 10'd0,   4'd0};
        vecs[4]  = '{4'd2, 4'hF, 3'd2, 3'd0, 1'b0, 2'd3, 10'd20,  4'd10};
        vecs[5]  = '{4'hF, 4'hF, 3'd2, 3'd4, 1'b1, 2'd0, 10'd0,   4'd6};
        vecs[6]  = '{4'd3, 4'd2, 3'd2, 3'd7, 1'b0, 2'd2, 10'd70,  4'd6};
        vecs[7]  = '{4'hF, 4'hF, 3'd1, 3'd1, 1'b1, 2'd0, 10'd25,  4'd9};
        vecs[8]  = '{4'hF, 4'hF, 3'd3, 3'd7, 1'b0, 2'd1, 10'd25,  4'd10};
        vecs[9]  = '{4'd4, 4'd4, 3'd3, 3'd2, 1'b1, 2'd0, 10'd75,  4'd8};
        vecs[10] = '{4'hF, 4'hF, 3'd4, 3'd7, 1'b0, 2'd1, 10'd75,  4'd9};
        vecs[11] = '{4'hF, 4'hF, 3'd3, 3'd1, 1'b1, 2'd0, 10'd0,   4'd7};

        rst = 1'b0; coin_valid = 1'b0; coin_sel = '0; sel_valid = 1'b0; sel_item = '0;
        sel_qty = '0; cancel = 1'b0; restock_valid = 1'b0; restock_item = '0;
        restock_qty = '0; chg_ready = 1'b0;

        repeat (2) tick();
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coin_reject", coin_reject, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_vend_qty", vend_qty, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_chg_denom", chg_denom, 0);
        chk("rst_stock", stock_flat, {5{4'd10}});
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int r = 0; r < 12; r++) begin
            if (vecs[r].c0 != 4'hF) coin(vecs[r].c0[2:0], 1'b0);
            if (vecs[r].c1 != 4'hF) coin(vecs[r].c1[2:0], 1'b0);
            do_sel(vecs[r].item, vecs[r].qty, vecs[r].is_vend, vecs[r].code, vecs[r].credit, 4'd0);
            if (vecs[r].item < 3'd5) chk("row_stock", stock_flat[int'(vecs[r].item)*4 +: 4], vecs[r].stock);
            chk("row_credit_after", credit, vecs[r].credit);
        end

        // Stock now {4:9, 3:7, 2:6, 1:9, 0:8}.
        restock(3'd2, 4'd5);
        chk("restock_add", stock_flat, {4'd9, 4'd7, 4'd11, 4'd9, 4'd8});
        restock(3'd6, 4'd3);
        chk("restock_bad_index", stock_flat, {4'd9, 4'd7, 4'd11, 4'd9, 4'd8});
        restock(3'd2, 4'd15);
        chk("restock_saturate", stock_flat, {4'd9, 4'd7, 4'd15, 4'd9, 4'd8});

        coin(3'd2, 1'b0);
        do_sel(3'd2, 3'd3, 1'b1, 2'd0, 10'd5, 4'd2);
        chk("vend_restock_same", stock_flat[11:8], 14);
        do_sel(3'd2, 3'd1, 1'b1, 2'd0, 10'd0, 4'd4);
        chk("vend_restock_sat", stock_flat[11:8], 15);

        repeat (4) coin(3'd4, 1'b0);
        coin(3'd3, 1'b0);
        coin(3'd4, 1'b1);
        chk("over_limit_credit", credit, 450);
        coin(3'd6, 1'b1);
        chk("bad_coin_credit", credit, 450);
        coin(3'd3, 1'b0);
        chk("max_credit", credit, 500);
        coin(3'd0, 1'b1);
        do_cancel();
        run_change(10'd500, {5{3'd4}}, 5);

        coin(3'd3, 1'b0); coin(3'd2, 1'b0); coin(3'd1, 1'b0); coin(3'd0, 1'b0);
        do_cancel();
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", chg_valid, 1);
            chk("stall_denom", chg_denom, 3);
            chk("stall_busy", busy, 1);
            tick();
        end
        coin(3'd0, 1'b1);
        chk("stall_credit", credit, 85);
        run_change(10'd85, 15'({3'd0, 3'd1, 3'd2, 3'd3}), 4);

        coin(3'd2, 1'b0); coin(3'd1, 1'b0); coin(3'd0, 1'b0);
        do_cancel();
        chk("pre_rst_denom", chg_denom, 2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_credit", credit, 0);
        chk("async_rst_chg_valid", chg_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_stock", stock_flat, {5{4'd10}});
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_credit", credit, 0);
        coin(3'd0, 1'b0);
        chk("post_rst_coin", credit, 5);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
